// File: rtl/simt_diverge_ctrl.sv
// Branch divergence/reconvergence controller: owns the active mask and sync PC, sequences SIMT stack pushes/pops.
// Optional statistics counters are built when SIMT_DIV_STATS_EN is defined.
module simt_diverge_ctrl #(
    parameter int          THREADS   = 4,
    parameter int          DEPTH     = 16,
    parameter logic [31:0] SYNC_NONE = 32'hFFFF_FFFF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               br_valid_i,
    output logic               br_ready_o,
    input  logic [THREADS-1:0] br_taken_i,
    input  logic [31:0]        br_target_i,
    input  logic [31:0]        br_fallthru_i,
    input  logic [31:0]        br_reconv_i,
    input  logic               issue_valid_i,
    input  logic [31:0]        issue_pc_i,
    output logic [THREADS-1:0] active_mask_o,
    output logic [31:0]        cur_sync_o,
    output logic               redirect_en_o,
    output logic [31:0]        redirect_pc_o,
    output logic               stall_o,
    output logic               push_en_o,
    output logic               pop_en_o,
    output logic [THREADS-1:0] new_mask_o,
    output logic [31:0]        new_sync_o,
    output logic [31:0]        new_addr_o,
    input  logic [THREADS-1:0] top_mask_i,
    input  logic [31:0]        top_sync_i,
    input  logic [31:0]        top_addr_i,
    output logic               err_o,
    output logic [15:0]        div_count_o,
    output logic [15:0]        reconv_count_o
);
    localparam int DW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {IDLE, PUSH_RC, PUSH_NT, POP, ERROR} state_t;

    state_t             state_q, state_d;
    logic [THREADS-1:0] mask_q, mask_d, t_q, t_d, n_q, n_d;
    logic [31:0]        sync_q, sync_d, target_q, target_d, fallthru_q, fallthru_d, reconv_q, reconv_d;
    logic [DW-1:0]      depth_q, depth_d;
    logic               rdir_pend_q, rdir_pend_d, err_q, err_d;
    logic [31:0]        rdir_pc_q, rdir_pc_d;
    logic [THREADS-1:0] taken_act, ntaken_act;
    logic               pop_req;

    assign taken_act  = br_taken_i & mask_q;
    assign ntaken_act = ~br_taken_i & mask_q;
    assign pop_req    = issue_valid_i && (issue_pc_i == sync_q) && (depth_q != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mask_q      <= '1;
            sync_q      <= SYNC_NONE;
            depth_q     <= '0;
            t_q         <= '0;
            n_q         <= '0;
            target_q    <= '0;
            fallthru_q  <= '0;
            reconv_q    <= '0;
            rdir_pend_q <= 1'b0;
            rdir_pc_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            sync_q      <= sync_d;
            depth_q     <= depth_d;
            t_q         <= t_d;
            n_q         <= n_d;
            target_q    <= target_d;
            fallthru_q  <= fallthru_d;
            reconv_q    <= reconv_d;
            rdir_pend_q <= rdir_pend_d;
            rdir_pc_q   <= rdir_pc_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        sync_d        = sync_q;
        depth_d       = depth_q;
        t_d           = t_q;
        n_d           = n_q;
        target_d      = target_q;
        fallthru_d    = fallthru_q;
        reconv_d      = reconv_q;
        rdir_pend_d   = 1'b0;
        rdir_pc_d     = rdir_pc_q;
        err_d         = err_q;
        br_ready_o    = 1'b0;
        stall_o       = 1'b0;
        push_en_o     = 1'b0;
        pop_en_o      = 1'b0;
        new_mask_o    = '0;
        new_sync_o    = '0;
        new_addr_o    = '0;
        // A uniform-taken branch accepted last cycle redirects now
        redirect_en_o = rdir_pend_q;
        redirect_pc_o = rdir_pend_q ? rdir_pc_q : '0;
        case (state_q)
            IDLE: begin
                if (pop_req) begin
                    stall_o = 1'b1;
                    state_d = POP;
                end else begin
                    br_ready_o = 1'b1;
                    if (br_valid_i && (taken_act != '0)) begin
                        if (ntaken_act == '0) begin
                            rdir_pend_d = 1'b1;
                            rdir_pc_d   = br_target_i;
                        end else if (depth_q <= DW'(DEPTH - 2)) begin
                            t_d        = taken_act;
                            n_d        = ntaken_act;
                            target_d   = br_target_i;
                            fallthru_d = br_fallthru_i;
                            reconv_d   = br_reconv_i;
                            state_d    = PUSH_RC;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ERROR;
                        end
                    end
                end
            end
            PUSH_RC: begin
                push_en_o  = 1'b1;
                new_mask_o = mask_q;
                new_sync_o = sync_q;
                new_addr_o = reconv_q;
                stall_o    = 1'b1;
                state_d    = PUSH_NT;
            end
            PUSH_NT: begin
                push_en_o     = 1'b1;
                new_mask_o    = n_q;
                new_sync_o    = reconv_q;
                new_addr_o    = fallthru_q;
                redirect_en_o = 1'b1;
                redirect_pc_o = target_q;
                stall_o       = 1'b1;
                mask_d        = t_q;
                sync_d        = reconv_q;
                depth_d       = depth_q + DW'(2);
                state_d       = IDLE;
            end
            POP: begin
                pop_en_o      = 1'b1;
                redirect_en_o = 1'b1;
                redirect_pc_o = top_addr_i;
                stall_o       = 1'b1;
                mask_d        = top_mask_i;
                sync_d        = top_sync_i;
                depth_d       = depth_q - DW'(1);
                state_d       = IDLE;
            end
            ERROR: begin
                stall_o       = 1'b1;
                redirect_en_o = 1'b0;
                redirect_pc_o = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign active_mask_o = mask_q;
    assign cur_sync_o    = sync_q;
    assign err_o         = err_q;

`ifdef SIMT_DIV_STATS_EN
    logic [15:0] div_cnt_q, rc_cnt_q;

    // Every completed divergence passes through PUSH_NT exactly once
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
            rc_cnt_q  <= '0;
        end else begin
            if (state_q == PUSH_NT && div_cnt_q != 16'hFFFF) div_cnt_q <= div_cnt_q + 16'd1;
            if (state_q == POP && rc_cnt_q != 16'hFFFF)      rc_cnt_q  <= rc_cnt_q + 16'd1;
        end
    end

    assign div_count_o    = div_cnt_q;
    assign reconv_count_o = rc_cnt_q;
`else
    assign div_count_o    = '0;
    assign reconv_count_o = '0;
`endif
endmodule

// File: tb/tb_simt_diverge_ctrl.sv
// Directed bench for simt_diverge_ctrl: vector table for single-branch responses, hand sequences for
// divergence, reconvergence, pop-vs-branch priority and stack overflow.
module tb_simt_diverge_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        br_valid, br_ready;
    logic [3:0]  br_taken;
    logic [31:0] br_target, br_fallthru, br_reconv;
    logic        issue_valid;
    logic [31:0] issue_pc;
    logic [3:0]  active_mask;
    logic [31:0] cur_sync;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        stall, push_en, pop_en;
    logic [3:0]  new_mask;
    logic [31:0] new_sync, new_addr;
    logic [3:0]  top_mask;
    logic [31:0] top_sync, top_addr;
    logic        err;
    logic [15:0] div_count, reconv_count;

    int tests = 0;
    int fails = 0;

    simt_diverge_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .br_valid_i(br_valid), .br_ready_o(br_ready), .br_taken_i(br_taken),
        .br_target_i(br_target), .br_fallthru_i(br_fallthru), .br_reconv_i(br_reconv),
        .issue_valid_i(issue_valid), .issue_pc_i(issue_pc),
        .active_mask_o(active_mask), .cur_sync_o(cur_sync),
        .redirect_en_o(redirect_en), .redirect_pc_o(redirect_pc),
        .stall_o(stall), .push_en_o(push_en), .pop_en_o(pop_en),
        .new_mask_o(new_mask), .new_sync_o(new_sync), .new_addr_o(new_addr),
        .top_mask_i(top_mask), .top_sync_i(top_sync), .top_addr_i(top_addr),
        .err_o(err), .div_count_o(div_count), .reconv_count_o(reconv_count)
    );

    always #5 clk = ~clk;

    // Stack fixture; force_full lets the overflow test nest deeper than four lanes naturally allow
    logic [3:0]  m_mask [0:31];
    logic [31:0] m_sync [0:31];
    logic [31:0] m_addr [0:31];
    int          sp;
    logic        force_full = 1'b0;

    always @(posedge clk) begin
        if (rst) sp <= 0;
        else if (push_en && sp < 32) begin
            m_mask[sp] <= new_mask;
            m_sync[sp] <= new_sync;
            m_addr[sp] <= new_addr;
            sp <= sp + 1;
        end else if (pop_en && sp > 0) sp <= sp - 1;
    end

    assign top_mask = force_full ? 4'hF : (sp > 0 ? m_mask[sp-1] : 4'h0);
    assign top_sync = sp > 0 ? m_sync[sp-1] : 32'h0;
    assign top_addr = sp > 0 ? m_addr[sp-1] : 32'h0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %h", name, act);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic div_stim(input logic [3:0] tk, input logic [31:0] tg, input logic [31:0] ft,
                            input logic [31:0] rc);
        br_valid = 1'b1; br_taken = tk; br_target = tg; br_fallthru = ft; br_reconv = rc;
        tick;
        br_valid = 1'b0;
        tick;
        tick;
    endtask

    task automatic pop_stim(input logic [31:0] pc);
        issue_valid = 1'b1; issue_pc = pc;
        tick;
        issue_valid = 1'b0;
        tick;
    endtask

    typedef struct {
        logic        br_valid;
        logic [3:0]  taken;
        logic [31:0] target;
        logic        issue_valid;
        logic [31:0] issue_pc;
        logic        exp_ready;
        logic        exp_stall;
        logic        exp_redir;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 4'h0, 32'h100, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 4'hF, 32'h100, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h100};
        vecs[2] = '{1'b1, 4'hF, 32'h200, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h200};
        vecs[3] = '{1'b1, 4'h0, 32'h300, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 4'hF, 32'h400, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 4'h0, 32'h0,   1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0};

        br_valid = 1'b0; br_taken = '0; br_target = '0; br_fallthru = '0; br_reconv = '0;
        issue_valid = 1'b0; issue_pc = '0;
        do_reset;
        settle;
        check("rst active_mask", active_mask, 4'hF);
        check("rst cur_sync", cur_sync, 32'hFFFF_FFFF);
        check("rst push_en", push_en, 0);
        check("rst pop_en", pop_en, 0);
        check("rst redirect_en", redirect_en, 0);
        check("rst br_ready", br_ready, 1);
        check("rst stall", stall, 0);
        check("rst err", err, 0);

        // Single-branch responses from the reset state
        for (int i = 0; i < 6; i++) begin
            br_valid = vecs[i].br_valid; br_taken = vecs[i].taken; br_target = vecs[i].target;
            issue_valid = vecs[i].issue_valid; issue_pc = vecs[i].issue_pc;
            settle;
            check($sformatf("vec%0d br_ready", i), br_ready, vecs[i].exp_ready);
            check($sformatf("vec%0d stall", i), stall, vecs[i].exp_stall);
            tick;
            br_valid = 1'b0; issue_valid = 1'b0;
            settle;
            check($sformatf("vec%0d redirect_en", i), redirect_en, vecs[i].exp_redir);
            check($sformatf("vec%0d redirect_pc", i), redirect_pc, vecs[i].exp_pc);
            check($sformatf("vec%0d push/pop", i), {push_en, pop_en}, 2'b00);
            check($sformatf("vec%0d mask", i), active_mask, 4'hF);
            tick;
        end

        // Divergence: T=3, N=C
        br_valid = 1'b1; br_taken = 4'b0011; br_target = 32'h100; br_fallthru = 32'h44; br_reconv = 32'h80;
        settle;
        check("div accept br_ready", br_ready, 1);
        tick;
        br_valid = 1'b0;
        settle;
        check("push_rc push_en", push_en, 1);
        check("push_rc entry", {new_mask, new_sync, new_addr}, {4'hF, 32'hFFFF_FFFF, 32'h80});
        check("push_rc stall", stall, 1);
        check("push_rc redirect_en", redirect_en, 0);
        tick;
        settle;
        check("push_nt push_en", push_en, 1);
        check("push_nt entry", {new_mask, new_sync, new_addr}, {4'hC, 32'h80, 32'h44});
        check("push_nt redirect", {redirect_en, redirect_pc}, {1'b1, 32'h100});
        check("push_nt stall", stall, 1);
        tick;
        settle;
        check("after div mask", active_mask, 4'h3);
        check("after div sync", cur_sync, 32'h80);
        check("after div push_en", push_en, 0);

        // First reconvergence: switch to the not-taken path
        issue_valid = 1'b1; issue_pc = 32'h80;
        settle;
        check("reconv1 stall", stall, 1);
        check("reconv1 br_ready", br_ready, 0);
        tick;
        issue_valid = 1'b0;
        settle;
        check("pop1 pop/push", {pop_en, push_en}, 2'b10);
        check("pop1 redirect", {redirect_en, redirect_pc}, {1'b1, 32'h44});
        tick;
        settle;
        check("pop1 mask", active_mask, 4'hC);
        check("pop1 sync", cur_sync, 32'h80);

        // Second reconvergence: full warp restored
        issue_valid = 1'b1; issue_pc = 32'h80;
        tick;
        issue_valid = 1'b0;
        settle;
        check("pop2 pop_en", pop_en, 1);
        check("pop2 redirect", {redirect_en, redirect_pc}, {1'b1, 32'h80});
        tick;
        settle;
        check("pop2 mask", active_mask, 4'hF);
        check("pop2 sync", cur_sync, 32'hFFFF_FFFF);
        check("pop2 stack empty", sp, 0);
        // depth is back to zero, so matching the sync PC again must be ignored
        issue_valid = 1'b1; issue_pc = 32'hFFFF_FFFF;
        settle;
        check("depth0 ignore stall", stall, 0);
        tick;
        issue_valid = 1'b0;
        settle;
        check("depth0 ignore pop", {pop_en, err}, 2'b00);
        tick;

        // Pop beats a simultaneous branch; the held branch is taken on the next IDLE cycle
        div_stim(4'b0001, 32'h200, 32'h48, 32'h90);
        settle;
        check("div2 mask", active_mask, 4'h1);
        br_valid = 1'b1; br_taken = 4'hF; br_target = 32'h300;
        issue_valid = 1'b1; issue_pc = 32'h90;
        settle;
        check("prio br_ready", br_ready, 0);
        check("prio stall", stall, 1);
        tick;
        issue_valid = 1'b0;
        settle;
        check("prio pop_en", pop_en, 1);
        check("prio pop br_ready", br_ready, 0);
        check("prio pop redirect", {redirect_en, redirect_pc}, {1'b1, 32'h48});
        tick;
        settle;
        check("prio held mask", active_mask, 4'hE);
        check("prio held br_ready", br_ready, 1);
        tick;
        br_valid = 1'b0;
        settle;
        check("prio held redirect", {redirect_en, redirect_pc}, {1'b1, 32'h300});
        check("prio held no push", push_en, 0);
        tick;
`ifdef SIMT_DIV_STATS_EN
        check("stats div_count", div_count, 16'd2);
        check("stats reconv_count", reconv_count, 16'd3);
`else
        check("stats div_count tied", div_count, 16'd0);
        check("stats reconv_count tied", reconv_count, 16'd0);
`endif
        pop_stim(32'h90);
        settle;
        check("prio final mask", active_mask, 4'hF);

        // Nest to depth 15 via 13 diverge/pop pairs plus one divergence
        do_reset;
        force_full = 1'b1;
        for (int k = 0; k < 13; k++) begin
            div_stim(4'b0011, 32'h500 + k, 32'h600 + k, 32'h1000 + 32'(k) * 16);
            pop_stim(32'h1000 + 32'(k) * 16);
        end
        div_stim(4'b0011, 32'h700, 32'h704, 32'h2000);
        settle;
        check("nest depth 15", sp, 15);
        check("nest mask", active_mask, 4'h3);
`ifdef SIMT_DIV_STATS_EN
        check("nest div_count", div_count, 16'd14);
        check("nest reconv_count", reconv_count, 16'd13);
`endif
        br_valid = 1'b1; br_taken = 4'b0001; br_target = 32'h800; br_fallthru = 32'h804; br_reconv = 32'h900;
        settle;
        check("ovf br_ready", br_ready, 1);
        tick;
        br_valid = 1'b0;
        settle;
        check("ovf err", err, 1);
        check("ovf stall", stall, 1);
        check("ovf push/pop/redir", {push_en, pop_en, redirect_en}, 3'b000);
        check("ovf br_ready", br_ready, 0);
        issue_valid = 1'b1; issue_pc = 32'h2000;
        tick;
        tick;
        issue_valid = 1'b0;
        settle;
        check("ovf sticky err", err, 1);
        check("ovf no stack change", sp, 15);
        check("ovf mask held", active_mask, 4'h3);
        force_full = 1'b0;
        do_reset;
        settle;
        check("rst2 err", err, 0);
        check("rst2 stall", stall, 0);
        check("rst2 br_ready", br_ready, 1);
        check("rst2 mask", active_mask, 4'hF);
        check("rst2 sync", cur_sync, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
